i2c_bus_mon: RTL
================

# i2c_bus_mon

Passive I2C bus monitor for the DE2-115 bus-checker build. It samples the external `scl`/`sda` pins with the board clock and detects START, STOP and repeated-START conditions. It shifts address and data bytes, checks the ACK bit of each byte, and keeps wrap-around event counters. It sits directly upstream of the 7-segment encoder stage: its 16-bit `disp` word feeds the four `enc7led` digit encoders, one nibble per digit, replacing the raw edge counters.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in each pin synchronizer (minimum 2).
- `CNT_W`, 16: width of every event counter.
- `clk`  in  1: board clock (50 MHz), all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `scl`  in  1: raw bus clock pin, asynchronous to `clk`.
- `sda`  in  1: raw bus data pin, asynchronous to `clk`.
- `sel`  in  2: display source select.
- `disp`  out  16: selected display word.
- `byte_vld`  out  1: one-cycle pulse when a byte plus its ACK bit is complete.
- `byte_q`  out  8: last completed byte.
- `byte_ack`  out  1: ACK bit of last byte (0 = ACK, 1 = NACK).
- `busy`  out  1: high between START and STOP.
- `err`  out  1: sticky flag for a STOP or repeated START inside a byte; cleared only by reset.

## Operation
- Synchronizer: `scl`/`sda` pass through `SYNC_STAGES` flops giving `scl_s`/`sda_s`. One extra register holds the previous values `scl_d`/`sda_d`.
- Condition detection, evaluated on the synchronized samples:
  - START: `scl_s & scl_d & sda_d & ~sda_s`.
  - STOP: `scl_s & scl_d & ~sda_d & sda_s`.
  - Bit strobe: `~scl_d & scl_s` (SCL rise); the bit value is `sda_s`.
  - If SCL and SDA change in the same sample, only the bit strobe is evaluated (`scl_d` low). No START or STOP is recognised.
- FSM states:
  - IDLE: on START, go to ADDR. Increment `start_cnt`, clear the bit counter, set `busy`.
  - ADDR: shift 8 bits MSB-first into the shift register. After the 8th strobe, go to ADDR_ACK.
  - ADDR_ACK: on the 9th strobe, latch `addr_q` from the shift register. Set `byte_q` and `byte_ack`, pulse `byte_vld`, then go to DATA. Bit 0 of the address (R/W) is not interpreted.
  - DATA: shift 8 bits. After the 8th strobe, go to DATA_ACK.
  - DATA_ACK: on the 9th strobe, latch `data_q` and update `byte_q`/`byte_ack`. Pulse `byte_vld`, then go to DATA.
- Counters:
  - `byte_cnt` increments on every `byte_vld`.
  - `nack_cnt` increments when `byte_vld` fires with ACK bit = 1.
- STOP in any non-IDLE state: go to IDLE and clear `busy`. If the bit counter is not 0, set `err`.
- START in any non-IDLE state (repeated START):
  - Go to ADDR and increment `start_cnt`.
  - If the bit counter is not 0, set `err`.
  - `busy` stays high.
- All counters are `CNT_W` bits and wrap from all-ones to 0 with no saturation.
- `disp` mux (combinational from registers):
  - `sel` = 0: `{addr_q, data_q}`.
  - `sel` = 1: `byte_cnt[15:0]`.
  - `sel` = 2: `start_cnt[15:0]`.
  - `sel` = 3: `nack_cnt[15:0]`.

## Timing
- Reset values: state IDLE; `disp` 0x0000; `byte_q` 0x00; `byte_ack` 0; `byte_vld` 0; `busy` 0; `err` 0; all counters and the shift register 0.
- Latency from a pin edge to the resulting detection is `SYNC_STAGES`+1 clocks (3 at the default).
- `byte_vld`, `byte_q`, `byte_ack`, `busy` and the counters all update in the same clock as the detection that causes them.
- `byte_vld` is high for exactly one `clk` cycle per byte. There is no back-pressure: a consumer must accept it that cycle.
- `disp` follows `sel` combinationally and follows the counters one clock after their update.
- Supported bus rate: each SCL high and low phase must last ≥ `SYNC_STAGES`+2 clocks. Faster buses give undefined counts but the FSM must never hang; START or STOP always recovers it.
- Reset asserted mid-byte: all state clears immediately. After release the FSM waits in IDLE for the next START, ignoring bits until then.

## Structure
- Shared package `i2c_mon_pkg`:
  - State enum `i2c_st_e` (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK).
  - Display-select constants `DISP_BYTES`, `DISP_BYTECNT`, `DISP_STARTCNT`, `DISP_NACKCNT`.
- One sub-module, `pin_sync`: parameterised `SYNC_STAGES` synchronizer, instantiated once each for `scl` and `sda`.
- The FSM, counters and display mux live in `i2c_bus_mon`.

## Test plan
- Write 0xA0 (ACK), 0x5C (ACK), then STOP:
  - Two `byte_vld` pulses, `byte_q` 0xA0 then 0x5C.
  - `disp` at `sel`=0 is 0xA05C; `byte_cnt` 2, `start_cnt` 1, `nack_cnt` 0.
  - `busy` falls at STOP; `err` 0.
- Address 0x91 answered with NACK, then STOP: `byte_ack` 1, `nack_cnt` 1, `disp` at `sel`=3 is 0x0001.
- Repeated START after 3 data bits:
  - `err` set, `start_cnt` 2, `busy` stays 1.
  - The next 9 bits are decoded as an address byte.
- Reset pulse mid-address, then a clean 0x3C transfer: all outputs 0 during reset; after release `byte_q` 0x3C and `byte_cnt` 1.
- Preload `byte_cnt` to 0xFFFF with 65535 bytes (or a forced value), then send one byte: `byte_cnt` wraps to 0x0000.
- SCL and SDA toggled in the same `clk` cycle while SCL is high: no START or STOP detected, and `start_cnt` is unchanged.

Source files
------------

// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
// Holds the FSM state encoding and the display-source select codes.
package i2c_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK
  } i2c_st_e;

  localparam logic [1:0] DISP_BYTES    = 2'd0;
  localparam logic [1:0] DISP_BYTECNT  = 2'd1;
  localparam logic [1:0] DISP_STARTCNT = 2'd2;
  localparam logic [1:0] DISP_NACKCNT  = 2'd3;

  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for one asynchronous bus pin; SYNC_STAGES clocks of latency.
// No flow control; the output simply trails the pin. Resets to 1 (idle bus level).
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pin_s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_bus_mon.sv
// Passive I2C monitor: START/STOP detection, byte/ACK decode, event counters, display mux.
// Pin edge to detection is SYNC_STAGES+1 clocks; no back-pressure, byte_vld is a 1-cycle pulse.
module i2c_bus_mon
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda,
  input  logic [1:0]  sel,
  output logic [15:0] disp,
  output logic        byte_vld,
  output logic [7:0]  byte_q,
  output logic        byte_ack,
  output logic        busy,
  output logic        err
);

  logic scl_s, sda_s;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  i2c_st_e              st_q, st_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           last_byte_q, last_byte_d;
  logic                 ack_q, ack_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]     start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0]     nack_cnt_q, nack_cnt_d;

  logic start_det, stop_det, strobe, scl_fall, mid_byte;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (scl),
    .pin_s (scl_s)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sda),
    .pin_s (sda_s)
  );

  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign strobe    = ~scl_prev_q & scl_s;
  assign scl_fall  = scl_prev_q & ~scl_s;

  // The SCL rise that precedes every STOP/repeated START is counted as a strobe;
  // a single strobe still pending in the current high phase is not a real data bit.
  assign mid_byte = (bit_cnt_q != '0) &&
                    !(pend_q && (bit_cnt_q == BIT_CNT_W'(1)));

  always_comb begin
    scl_prev_d  = scl_s;
    sda_prev_d  = sda_s;
    st_d        = st_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_byte_d = last_byte_q;
    ack_d       = ack_q;
    vld_d       = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    byte_cnt_d  = byte_cnt_q;
    start_cnt_d = start_cnt_q;
    nack_cnt_d  = nack_cnt_q;
    pend_d      = pend_q;

    if (strobe) begin
      pend_d = 1'b1;
    end else if (scl_fall) begin
      pend_d = 1'b0;
    end

    if (start_det) begin
      if ((st_q != IDLE) && mid_byte) begin
        err_d = 1'b1;
      end
      st_d        = ADDR;
      start_cnt_d = start_cnt_q + CNT_W'(1);
      bit_cnt_d   = '0;
      busy_d      = 1'b1;
    end else if (stop_det) begin
      if (st_q != IDLE) begin
        if (mid_byte) begin
          err_d = 1'b1;
        end
        st_d      = IDLE;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end
    end else if (strobe) begin
      case (st_q)
        ADDR, DATA: begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            st_d = (st_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (st_q == ADDR_ACK) begin
            addr_d = shift_q;
          end else begin
            data_d = shift_q;
          end
          last_byte_d = shift_q;
          ack_d       = sda_s;
          vld_d       = 1'b1;
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          if (sda_s) begin
            nack_cnt_d = nack_cnt_q + CNT_W'(1);
          end
          bit_cnt_d = '0;
          st_d      = DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      st_q        <= IDLE;
      bit_cnt_q   <= '0;
      pend_q      <= 1'b0;
      shift_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_byte_q <= '0;
      ack_q       <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      byte_cnt_q  <= '0;
      start_cnt_q <= '0;
      nack_cnt_q  <= '0;
    end else begin
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      st_q        <= st_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_byte_q <= last_byte_d;
      ack_q       <= ack_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      byte_cnt_q  <= byte_cnt_d;
      start_cnt_q <= start_cnt_d;
      nack_cnt_q  <= nack_cnt_d;
    end
  end

  logic [15:0] byte_cnt_16, start_cnt_16, nack_cnt_16;

  if (CNT_W >= 16) begin : g_cnt_wide
    assign byte_cnt_16  = byte_cnt_q[15:0];
    assign start_cnt_16 = start_cnt_q[15:0];
    assign nack_cnt_16  = nack_cnt_q[15:0];
  end else begin : g_cnt_narrow
    assign byte_cnt_16  = {{(16-CNT_W){1'b0}}, byte_cnt_q};
    assign start_cnt_16 = {{(16-CNT_W){1'b0}}, start_cnt_q};
    assign nack_cnt_16  = {{(16-CNT_W){1'b0}}, nack_cnt_q};
  end

  always_comb begin
    disp = {addr_q, data_q};
    case (sel)
      DISP_BYTES:    disp = {addr_q, data_q};
      DISP_BYTECNT:  disp = byte_cnt_16;
      DISP_STARTCNT: disp = start_cnt_16;
      DISP_NACKCNT:  disp = nack_cnt_16;
      default:       disp = {addr_q, data_q};
    endcase
  end

  assign byte_vld = vld_q;
  assign byte_q   = last_byte_q;
  assign byte_ack = ack_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
